// File: rtl/press_pattern_gen_if.sv
// Command handshake bundle for the press pattern generator.
// The master issues commands; the slave (generator) reports readiness.
interface press_pattern_gen_if;
   logic       cmd_valid;
   logic       cmd_long;
   logic [3:0] cmd_count;
   logic       cmd_ready;

   modport master (
      output cmd_valid,
      output cmd_long,
      output cmd_count,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_long,
      input  cmd_count,
      output cmd_ready
   );
endinterface

// File: rtl/press_pattern_gen.sv
// Emulated push-button: emits N short or long presses, each followed
// by a release gap, then pulses done for one cycle.
module press_pattern_gen #(
   parameter int SHORT_TICKS = 30,
   parameter int LONG_TICKS  = 200,
   parameter int GAP_TICKS   = 50,
   parameter int CNT_W       = 8
) (
   input  logic                clk_100Hz,
   input  logic                rst,
   press_pattern_gen_if.slave  cmd,
   output logic                button,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      GAP   = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(SHORT_TICKS - 1);
   localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_TICKS - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] tick_q, tick_d;
   logic [3:0]       rem_q, rem_d;
   logic             long_q, long_d;
   logic             button_q, button_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic accept;
   logic tick_zero;

   assign accept    = cmd.cmd_valid && (state_q == IDLE);
   assign tick_zero = (tick_q == '0);

   always_ff @(posedge clk_100Hz) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = PRESS;
         PRESS:   if (tick_zero) state_d = GAP;
         GAP:     if (tick_zero) state_d = (rem_q != 4'd0) ? PRESS : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Counters and registered outputs all follow the next state, so the
   // pins change on the same edge the state does.
   always_comb begin
      tick_d = tick_q;
      rem_d  = rem_q;
      long_d = long_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               long_d = cmd.cmd_long;
               rem_d  = (cmd.cmd_count == 4'd0) ? 4'd1 : cmd.cmd_count;
               tick_d = cmd.cmd_long ? LONG_LD : SHORT_LD;
            end
         end
         PRESS: begin
            if (tick_zero) begin
               rem_d  = rem_q - 4'd1;
               tick_d = GAP_LD;
            end else begin
               tick_d = tick_q - 1'b1;
            end
         end
         GAP: begin
            if (tick_zero) begin
               if (rem_q != 4'd0) begin
                  tick_d = long_q ? LONG_LD : SHORT_LD;
               end else begin
                  tick_d = '0;
               end
            end else begin
               tick_d = tick_q - 1'b1;
            end
         end
         default: begin
            tick_d = '0;
            rem_d  = 4'd0;
         end
      endcase
      button_d = (state_d == PRESS);
      busy_d   = (state_d != IDLE);
      done_d   = (state_q == GAP) && (state_d == IDLE);
   end

   always_ff @(posedge clk_100Hz) begin
      if (rst) begin
         tick_q   <= '0;
         rem_q    <= 4'd0;
         long_q   <= 1'b0;
         button_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         tick_q   <= tick_d;
         rem_q    <= rem_d;
         long_q   <= long_d;
         button_q <= button_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign cmd.cmd_ready = (state_q == IDLE);
   assign button        = button_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule
